fsincos_pack_out: RTL

//  Final stage of the fsincos datapath, directly downstream of the polynomial FMA stage.
//  - Takes the polynomial result (sign/exp/frac40), the 32-bit D-or-X operand and the control flags.
//  - Applies the final x*P(x^2) multiply when required, then forced-zero and sign-flip.
//  - Rounds and packs to IEEE-754 binary32 and buffers results in an output FIFO read by the consumer.

---
 rtl/fsincos_pack_out.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/fsincos_pack_out.sv
`default_nettype none
// ============================================================================
// fsincos_pack_out : final x*P(x^2) multiply, RNE round and binary32 pack,
//                    results buffered in an output FIFO.
// Option macro     : FSINCOS_OUT_STATUS_EN adds o_status per FIFO entry.
// Revision         : 1.0
// ============================================================================
module fsincos_pack_out #(
  parameter int FRAC_WIDTH = 40,
  parameter int EXP_WIDTH  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_valid,
  input  logic                  i_sign_p,
  input  logic [EXP_WIDTH-1:0]  i_exp_p,
  input  logic [FRAC_WIDTH-1:0] i_frac_p,
  input  logic                  i_sign_x,
  input  logic [EXP_WIDTH-1:0]  i_exp_x,
  input  logic [31:0]           i_frac_x,
  input  logic                  i_sel_DorX,
  input  logic                  i_X_ZERO_CAL,
  input  logic                  i_RESULT_SIGN_FLIP,
  input  logic                  i_rd,
  output logic [31:0]           o_data,
  output logic                  o_empty,
  output logic                  o_full,
  output logic                  o_overflow
`ifdef FSINCOS_OUT_STATUS_EN
  ,output logic [2:0]           o_status
`endif
);

  localparam int PRW = FRAC_WIDTH + 32;
  localparam int MW  = PRW - 1;
  localparam int XW  = EXP_WIDTH + 2;
  localparam int PW  = $clog2(FIFO_DEPTH);
`ifdef FSINCOS_OUT_STATUS_EN
  localparam int DW  = 35;
`else
  localparam int DW  = 32;
`endif
  localparam logic [EXP_WIDTH-1:0] c_ZERO_CODE = {1'b1, {(EXP_WIDTH-1){1'b0}}};
  localparam logic [XW-1:0]        c_BIAS      = XW'(127);
  localparam logic [XW-1:0]        c_EXP_INF   = XW'(255);
  localparam logic [PW:0]          c_CNT_ONE   = (PW+1)'(1);
  localparam logic [PW:0]          c_CNT_FULL  = (PW+1)'(FIFO_DEPTH);

  // ---------------- S1: optional multiply, zero/sign handling ----------------
  logic [PRW-1:0] w_prod;
  logic [XW-1:0]  w_ep_ext, w_ex_ext, w_esum;
  logic [MW-1:0]  w_s1_mant;
  logic [XW-1:0]  w_s1_exp;
  logic           w_s1_sign, w_s1_zero;

  assign w_prod   = {{32{1'b0}}, i_frac_p} * {{FRAC_WIDTH{1'b0}}, i_frac_x};
  assign w_ep_ext = {{2{i_exp_p[EXP_WIDTH-1]}}, i_exp_p};
  assign w_ex_ext = {{2{i_exp_x[EXP_WIDTH-1]}}, i_exp_x};
  assign w_esum   = w_ep_ext + w_ex_ext + {{(XW-1){1'b0}}, w_prod[PRW-1]};

  always_comb begin
    w_s1_mant = '0;
    w_s1_exp  = '0;
    w_s1_sign = 1'b0;
    w_s1_zero = 1'b0;
    if (i_sel_DorX) begin
      w_s1_mant = {i_frac_p[FRAC_WIDTH-2:0], 32'd0};
      w_s1_exp  = w_ep_ext;
      w_s1_sign = i_sign_p;
      w_s1_zero = (i_exp_p == c_ZERO_CODE);
    end else begin
      // Both operands carry an explicit leading one, so the product leads at bit 71 or 70
      w_s1_mant = w_prod[PRW-1] ? w_prod[PRW-2:0] : {w_prod[PRW-3:0], 1'b0};
      w_s1_exp  = w_esum;
      w_s1_sign = i_sign_p ^ i_sign_x;
      w_s1_zero = (i_exp_p == c_ZERO_CODE) || (i_exp_x == c_ZERO_CODE);
    end
    if (i_X_ZERO_CAL) begin
      w_s1_zero = 1'b1;
      w_s1_sign = i_sign_x;
    end
    w_s1_sign = w_s1_sign ^ i_RESULT_SIGN_FLIP;
  end

  logic           r_s1_valid, r_s1_sign, r_s1_zero;
  logic [XW-1:0]  r_s1_exp;
  logic [MW-1:0]  r_s1_mant;

  // ---------------- S2: round to nearest even and pack ----------------
  logic [22:0]    w_m23;
  logic           w_g, w_s, w_inc, w_inf, w_flush;
  logic [23:0]    w_rsum;
  logic [XW-1:0]  w_biased;
  logic [31:0]    w_word;
  logic [DW-1:0]  w_s2_word;

  assign w_m23    = r_s1_mant[MW-1 -: 23];
  assign w_g      = r_s1_mant[MW-24];
  assign w_s      = |r_s1_mant[MW-25:0];
  assign w_inc    = w_g & (w_s | w_m23[0]);
  assign w_rsum   = {1'b0, w_m23} + {23'd0, w_inc};
  assign w_biased = r_s1_exp + c_BIAS + {{(XW-1){1'b0}}, w_rsum[23]};
  assign w_inf    = !r_s1_zero && !w_biased[XW-1] && (w_biased >= c_EXP_INF);
  assign w_flush  = !r_s1_zero && (w_biased[XW-1] || (w_biased == '0));

  always_comb begin
    w_word = {w_s1_unused_guard(r_s1_sign), w_biased[7:0], w_rsum[22:0]};
    if (r_s1_zero || w_flush) begin
      w_word = {r_s1_sign, 31'd0};
    end else if (w_inf) begin
      w_word = {r_s1_sign, 8'hFF, 23'd0};
    end
  end

  function automatic logic w_s1_unused_guard(input logic s);
    return s;
  endfunction

`ifdef FSINCOS_OUT_STATUS_EN
  logic w_inexact;
  assign w_inexact = !r_s1_zero && (w_g || w_s || w_flush || w_inf);
  assign w_s2_word = {w_inf, w_flush, w_inexact, w_word};
`else
  assign w_s2_word = w_word;
`endif

  logic           r_s2_valid;
  logic [DW-1:0]  r_s2_word;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_s1_valid <= 1'b0;
      r_s1_sign  <= 1'b0;
      r_s1_zero  <= 1'b0;
      r_s1_exp   <= '0;
      r_s1_mant  <= '0;
      r_s2_valid <= 1'b0;
      r_s2_word  <= '0;
    end else begin
      r_s1_valid <= i_valid;
      if (i_valid) begin
        r_s1_sign <= w_s1_sign;
        r_s1_zero <= w_s1_zero;
        r_s1_exp  <= w_s1_exp;
        r_s1_mant <= w_s1_mant;
      end
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) r_s2_word <= w_s2_word;
    end
  end

  // ---------------- Output FIFO with registered head ----------------
  logic [DW-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr, r_rd_ptr, w_rd_nxt;
  logic [PW:0]   r_count;
  logic [DW-1:0] r_head;
  logic          r_overflow;
  logic          w_full, w_empty, w_rd, w_wr_ok;

  assign w_full   = (r_count == c_CNT_FULL);
  assign w_empty  = (r_count == '0);
  assign w_rd     = i_rd && !w_empty;
  assign w_wr_ok  = r_s2_valid && (!w_full || w_rd);
  assign w_rd_nxt = r_rd_ptr + PW'(1);

  always_ff @(posedge i_clk) begin
    if (w_wr_ok) r_mem[r_wr_ptr] <= r_s2_word;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_head     <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr_ok) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_rd)    r_rd_ptr <= w_rd_nxt;
      r_count <= r_count + {{PW{1'b0}}, w_wr_ok} - {{PW{1'b0}}, w_rd};
      if (r_s2_valid && w_full && !w_rd) r_overflow <= 1'b1;
      // The next head bypasses the memory when it is being written this very cycle
      if (w_rd) begin
        if (r_count == c_CNT_ONE) begin
          if (w_wr_ok) r_head <= r_s2_word;
        end else begin
          r_head <= r_mem[w_rd_nxt];
        end
      end else if (w_wr_ok && w_empty) begin
        r_head <= r_s2_word;
      end
    end
  end

  assign o_data     = r_head[31:0];
  assign o_empty    = w_empty;
  assign o_full     = w_full;
  assign o_overflow = r_overflow;
`ifdef FSINCOS_OUT_STATUS_EN
  assign o_status   = r_head[34:32];
`endif

endmodule
`default_nettype wire
